freepdk45_sram_ctrl_64x176: RTL and testbench
=============================================

FREEPDK45_SRAM_CTRL_64X176 -- requirements
Module: freepdk45_sram_ctrl_64x176

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 176, word width.
REQ-003 SHALL have parameter NUM_WMASKS, default 8, write-mask lanes (22 bits each).
REQ-004 SHALL have parameter RSP_DEPTH, default 4, read-response FIFO entries (power of 2, >=2).
REQ-005 SHALL have ports in this order: clk0 in 1, single clock.
REQ-006 rst0_n in 1: reset, asynchronous, active-low.
REQ-007 req_valid in 1, req_ready out 1: request handshake.
REQ-008 req_we in 1: 1 = write, 0 = read.
REQ-009 req_addr in ADDR_WIDTH, req_wmask in NUM_WMASKS, req_wdata in DATA_WIDTH: request payload.
REQ-010 rsp_valid out 1, rsp_ready in 1, rsp_rdata out DATA_WIDTH: read-response handshake.
REQ-011 sram_csb0, sram_web0 out 1, both active-low: macro chip select and write enable.
REQ-012 sram_wmask0 out NUM_WMASKS, sram_addr0 out ADDR_WIDTH, sram_din0 out DATA_WIDTH: macro port drive.
REQ-013 sram_dout0 in DATA_WIDTH: macro read data.

Function
REQ-014 SHALL transfer a request on a clk0 rising edge where req_valid && req_ready (edge T).
REQ-015 SHALL drive all sram_* outputs from registers updated at edge T; macro samples them at edge T+1.
REQ-016 Cycles with no accepted request: sram_csb0=1, sram_web0=1, sram_wmask0=0; addr/din hold previous values.
REQ-017 Accepted write: sram_csb0=0, sram_web0=0, sram_wmask0/addr0/din0 = request fields, for exactly one cycle; no response.
REQ-018 Accepted read: sram_csb0=0, sram_web0=1, sram_wmask0=0, sram_addr0=req_addr, for exactly one cycle.
REQ-019 SHALL capture sram_dout0 into the response FIFO at edge T+2 for a read accepted at edge T; rsp_valid high after edge T+2 (fixed 2-cycle latency when FIFO is empty).
REQ-020 SHALL track in-flight reads with a 2-stage valid pipeline (issued, capture).
REQ-021 req_ready = (fifo_count + inflight_reads) < RSP_DEPTH; SHALL NOT depend on req_valid or req_we.
REQ-022 SHALL sustain one request per cycle when rsp_ready is held high.
REQ-023 Response FIFO: first-word-fall-through; rsp_rdata valid whenever rsp_valid; pops on rsp_valid && rsp_ready.
REQ-024 Simultaneous push and pop on a full or empty FIFO SHALL both take effect; count unchanged (full) or pass-through next cycle (empty).
REQ-025 Responses SHALL return in request order; read after write to same address returns written data (write issued first).
REQ-026 FIFO pointers wrap modulo RSP_DEPTH; overflow impossible by REQ-021; bench SHALL assert it never occurs.
REQ-027 wmask all-zero write SHALL still issue a macro cycle (csb0=0, web0=0).

Reset
REQ-028 On rst0_n low: sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0, rsp_valid=0, FIFO count 0, in-flight pipeline cleared.
REQ-029 Reset mid-operation SHALL drop in-flight reads and queued responses; no response after release.
REQ-030 req_ready SHALL be 0 while rst0_n is low and 1 on the first edge after release.

Structure
REQ-031 Package sram_ctrl_pkg SHALL hold ADDR_WIDTH, DATA_WIDTH, NUM_WMASKS, lane width 22 and a request struct typedef.
REQ-032 Response FIFO SHALL be sub-module sram_rsp_fifo (parameterised width/depth, count output).
REQ-033 Top contains request issue registers, in-flight pipeline, credit logic only.

Verification
REQ-034 Write addr 5, wmask 8'hFF, data D; read addr 5 -> rsp_rdata=D, rsp_valid 2 cycles after read accept.
REQ-035 Write addr 9 all-ones, then wmask 8'h01 with zeros -> read returns all-ones except bits [21:0]=0.
REQ-036 6 back-to-back reads, rsp_ready=0 -> req_ready falls after 4 accepts; release rsp_ready -> 6 responses in order, no loss.
REQ-037 Continuous reads with rsp_ready=1 -> one request accepted and one response per cycle, req_ready never low.
REQ-038 Assert rst0_n low 1 cycle after a read accept -> no rsp_valid afterwards, sram_csb0=1 immediately.
REQ-039 Idle 10 cycles -> sram_csb0=1, sram_web0=1 every cycle, no macro access.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared widths and request type for the 64x176 FreePDK45 SRAM controller.
package sram_ctrl_pkg;

  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 176;
  localparam int NUM_WMASKS = 8;
  localparam int LANE_WIDTH = 22;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [NUM_WMASKS-1:0] wmask;
    logic [DATA_WIDTH-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// First-word-fall-through read-response FIFO with an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sram_rsp_fifo #(
  parameter int WIDTH = 176,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid    = (count != '0);
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && valid;
  assign do_push  = push && ((count != FULL_COUNT) || do_pop);

  // Storage array: data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and count bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/freepdk45_sram_ctrl_64x176.sv
// Request/response front end for a single-port 64x176 FreePDK45 SRAM macro.
// Macro pins are registered at the accept edge; read data is captured two
// edges later into a response FIFO, and credits keep that FIFO from overflowing.
module freepdk45_sram_ctrl_64x176
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = sram_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH,
  parameter int NUM_WMASKS = sram_ctrl_pkg::NUM_WMASKS,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int OW = CW + 2;

  logic          accept;
  logic          issued_v;
  logic          capture_v;
  logic [CW-1:0] fifo_count;
  logic [OW-1:0] occupancy;

  // Every read already in flight holds a FIFO slot, so a full FIFO plus
  // pipeline can never receive more data than it has room for.
  assign occupancy = OW'(fifo_count) + OW'(issued_v) + OW'(capture_v);
  assign req_ready = rst0_n && (occupancy < OW'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;

  // Macro pin registers: one active cycle per accepted request, idle otherwise.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
    end else if (accept) begin
      sram_csb0   <= 1'b0;
      sram_web0   <= ~req_we;
      sram_wmask0 <= req_we ? req_wmask : '0;
      sram_addr0  <= req_addr;
      if (req_we) begin
        sram_din0 <= req_wdata;
      end
    end else begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
    end
  end

  // Two-stage read tracker: issued (macro samples next edge), then capture (dout valid).
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      issued_v  <= 1'b0;
      capture_v <= 1'b0;
    end else begin
      issued_v  <= accept && !req_we;
      capture_v <= issued_v;
    end
  end

  sram_rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk0),
    .rst_n     (rst0_n),
    .push      (capture_v),
    .push_data (sram_dout0),
    .pop       (rsp_ready),
    .pop_data  (rsp_rdata),
    .valid     (rsp_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_freepdk45_sram_ctrl_64x176.sv
// Bench for freepdk45_sram_ctrl_64x176 with a behavioural SRAM macro model.
module tb_freepdk45_sram_ctrl_64x176;
  import sram_ctrl_pkg::*;

  localparam int RSP_DEPTH = 4;
  localparam int NWORDS    = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;

  logic                  clk0 = 1'b0;
  logic                  rst0_n = 1'b0;
  logic                  req_valid, req_ready, req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [NUM_WMASKS-1:0] req_wmask;
  word_t                 req_wdata;
  logic                  rsp_valid, rsp_ready;
  word_t                 rsp_rdata;
  logic                  sram_csb0, sram_web0;
  logic [NUM_WMASKS-1:0] sram_wmask0;
  logic [ADDR_WIDTH-1:0] sram_addr0;
  word_t                 sram_din0;
  word_t                 sram_dout0 = '0;

  int    compareCount = 0;
  int    mismatchCount = 0;
  int    cycleCount = 0;
  int    macroAccessCount = 0;
  bit    preloaded = 1'b0;
  word_t sbQueue[$];
  word_t refMem   [NWORDS];
  word_t macroMem [NWORDS];
  logic [ADDR_WIDTH-1:0] lastAddr;

  freepdk45_sram_ctrl_64x176 #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WMASKS (NUM_WMASKS),
    .RSP_DEPTH  (RSP_DEPTH)
  ) dut (
    .clk0        (clk0),
    .rst0_n      (rst0_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wmask   (req_wmask),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  always #5 clk0 = ~clk0;

  always @(posedge clk0) cycleCount <= cycleCount + 1;

  function automatic word_t patternFor(int idx);
    logic [LANE_WIDTH-1:0] lane;
    lane = LANE_WIDTH'(idx * 37 + 5);
    return {NUM_WMASKS{lane}};
  endfunction

  function automatic sram_req_t mkReq(logic we, int addr, logic [NUM_WMASKS-1:0] wmask, word_t wdata);
    sram_req_t r;
    r.we    = we;
    r.addr  = ADDR_WIDTH'(addr);
    r.wmask = wmask;
    r.wdata = wdata;
    return r;
  endfunction

  // Behavioural single-port macro: samples its pins on the rising edge, dout valid after that edge.
  always @(posedge clk0) begin
    word_t merged;
    if (!preloaded) begin
      for (int i = 0; i < NWORDS; i++) macroMem[i] <= patternFor(i);
      preloaded <= 1'b1;
    end else if (!sram_csb0) begin
      macroAccessCount <= macroAccessCount + 1;
      if (!sram_web0) begin
        merged = macroMem[sram_addr0];
        for (int i = 0; i < NUM_WMASKS; i++)
          if (sram_wmask0[i]) merged[i*LANE_WIDTH +: LANE_WIDTH] = sram_din0[i*LANE_WIDTH +: LANE_WIDTH];
        macroMem[sram_addr0] <= merged;
      end else begin
        sram_dout0 <= macroMem[sram_addr0];
      end
    end
  end

  task automatic checkOutput(string tag, word_t observed, word_t expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  // Response side: every popped response must match the oldest expected entry.
  always @(negedge clk0) begin
    word_t expected;
    if (rst0_n) begin
      checkOutput("fifoOverflow", word_t'(dut.u_rsp_fifo.count > 3'(RSP_DEPTH)), '0);
      checkOutput("outstandingBound", word_t'(sbQueue.size() > RSP_DEPTH), '0);
      if (rsp_valid && rsp_ready) begin
        checkOutput("rspHasExpected", word_t'(sbQueue.size() != 0), word_t'(1));
        if (sbQueue.size() != 0) begin
          expected = sbQueue.pop_front();
          checkOutput("rspData", rsp_rdata, expected);
        end
      end
    end
  end

  // Drive one request from #1 after an edge; returns #1 after the accepting edge.
  task automatic applyStimulus(input sram_req_t req, output int acceptCycle);
    int guard = 0;
    req_valid = 1'b1;
    req_we    = req.we;
    req_addr  = req.addr;
    req_wmask = req.wmask;
    req_wdata = req.wdata;
    while (!req_ready && guard < 50) begin
      @(posedge clk0); #1;
      guard++;
    end
    checkOutput("acceptWithinBudget", word_t'(guard < 50), word_t'(1));
    if (guard >= 50) begin
      req_valid   = 1'b0;
      acceptCycle = -1;
      return;
    end
    @(posedge clk0); #1;
    acceptCycle = cycleCount;
    req_valid   = 1'b0;
    lastAddr    = req.addr;
    if (req.we) begin
      for (int i = 0; i < NUM_WMASKS; i++)
        if (req.wmask[i]) refMem[req.addr][i*LANE_WIDTH +: LANE_WIDTH] = req.wdata[i*LANE_WIDTH +: LANE_WIDTH];
      checkOutput("wrDin", sram_din0, req.wdata);
    end else begin
      sbQueue.push_back(refMem[req.addr]);
    end
    checkOutput("issueCsb", word_t'(sram_csb0), '0);
    checkOutput("issueWeb", word_t'(sram_web0), word_t'(!req.we));
    checkOutput("issueWmask", word_t'(sram_wmask0), word_t'(req.we ? req.wmask : '0));
    checkOutput("issueAddr", word_t'(sram_addr0), word_t'(req.addr));
  endtask

  task automatic drainResponses(string tag);
    int guard = 0;
    while (sbQueue.size() != 0 && guard < 40) begin
      @(posedge clk0); #1;
      guard++;
    end
    checkOutput(tag, word_t'(sbQueue.size()), '0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, prevCyc, accessBefore;
    word_t dataD;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wmask = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NWORDS; i++) refMem[i] = patternFor(i);

    // Reset values while rst0_n is held low
    repeat (3) @(posedge clk0);
    #1;
    checkOutput("rstCsb", word_t'(sram_csb0), word_t'(1));
    checkOutput("rstWeb", word_t'(sram_web0), word_t'(1));
    checkOutput("rstWmask", word_t'(sram_wmask0), '0);
    checkOutput("rstAddr", word_t'(sram_addr0), '0);
    checkOutput("rstDin", sram_din0, '0);
    checkOutput("rstRspValid", word_t'(rsp_valid), '0);
    checkOutput("rstReqReady", word_t'(req_ready), '0);
    rst0_n = 1'b1;
    #1;
    checkOutput("readyAfterRelease", word_t'(req_ready), word_t'(1));
    @(posedge clk0); #1;

    // Full-mask write then read of address 5 with two-cycle latency
    dataD = {16'hBEEF, {5{32'hC0DE_1234}}};
    applyStimulus(mkReq(1'b1, 5, 8'hFF, dataD), cyc);
    applyStimulus(mkReq(1'b0, 5, 8'hFF, '0), cyc);
    checkOutput("latencyT0", word_t'(rsp_valid), '0);
    @(posedge clk0); #1;
    checkOutput("latencyT1", word_t'(rsp_valid), '0);
    checkOutput("readIdleCsb", word_t'(sram_csb0), word_t'(1));
    @(posedge clk0); #1;
    checkOutput("latencyT2", word_t'(rsp_valid), word_t'(1));
    drainResponses("drainBasic");

    // Partial-mask overwrite of lane 0, then an all-zero mask write that changes nothing
    applyStimulus(mkReq(1'b1, 9, 8'hFF, '1), cyc);
    applyStimulus(mkReq(1'b1, 9, 8'h01, '0), cyc);
    applyStimulus(mkReq(1'b0, 9, 8'h00, '0), cyc);
    applyStimulus(mkReq(1'b1, 9, 8'h00, {6{32'h1357_9BDF}}), cyc);
    applyStimulus(mkReq(1'b0, 9, 8'h5A, '0), cyc);
    drainResponses("drainMask");

    // Six reads with responses stalled: the fifth must wait for credit
    rsp_ready = 1'b0;
    prevCyc = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(mkReq(1'b0, 10 + k, 8'h00, '0), cyc);
      if (k > 0) checkOutput("stallBackToBack", word_t'(cyc - prevCyc), word_t'(1));
      prevCyc = cyc;
    end
    checkOutput("readyLowWhenFull", word_t'(req_ready), '0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk0); #1;
      checkOutput("readyHeldLow", word_t'(req_ready), '0);
      checkOutput("rspHeldValid", word_t'(rsp_valid), word_t'(1));
    end
    rsp_ready = 1'b1;
    for (int k = 4; k < 6; k++) applyStimulus(mkReq(1'b0, 10 + k, 8'h00, '0), cyc);
    drainResponses("drainStall");

    // Continuous reads with responses always accepted
    prevCyc = 0;
    for (int k = 0; k < 16; k++) begin
      checkOutput("streamReady", word_t'(req_ready), word_t'(1));
      applyStimulus(mkReq(1'b0, (k * 7 + 3) % NWORDS, 8'h00, '0), cyc);
      if (k > 0) checkOutput("streamBackToBack", word_t'(cyc - prevCyc), word_t'(1));
      prevCyc = cyc;
    end
    drainResponses("drainStream");
    checkOutput("streamDrainCycles", word_t'((cycleCount - prevCyc) <= 3), word_t'(1));

    // Ten idle cycles: no macro activity, address held
    accessBefore = macroAccessCount;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk0); #1;
      checkOutput("idleCsb", word_t'(sram_csb0), word_t'(1));
      checkOutput("idleWeb", word_t'(sram_web0), word_t'(1));
      checkOutput("idleWmask", word_t'(sram_wmask0), '0);
      checkOutput("idleAddrHold", word_t'(sram_addr0), word_t'(lastAddr));
    end
    checkOutput("idleNoAccess", word_t'(macroAccessCount - accessBefore), '0);

    // Reset one cycle after a read accept drops that read
    applyStimulus(mkReq(1'b0, 20, 8'h00, '0), cyc);
    @(posedge clk0); #1;
    rst0_n = 1'b0;
    #1;
    checkOutput("midRstCsb", word_t'(sram_csb0), word_t'(1));
    checkOutput("midRstReady", word_t'(req_ready), '0);
    checkOutput("midRstRspValid", word_t'(rsp_valid), '0);
    sbQueue.delete();
    repeat (2) @(posedge clk0);
    #1;
    rst0_n = 1'b1;
    #1;
    checkOutput("midRstReadyAfter", word_t'(req_ready), word_t'(1));
    for (int k = 0; k < 6; k++) begin
      @(posedge clk0); #1;
      checkOutput("noRspAfterRst", word_t'(rsp_valid), '0);
    end

    // Normal operation resumes after reset
    applyStimulus(mkReq(1'b1, 33, 8'hF0, {11{16'h0F0F}}), cyc);
    applyStimulus(mkReq(1'b0, 33, 8'h00, '0), cyc);
    drainResponses("drainAfterRst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
